// File: rtl/sched_pkg.sv
// Shared types for the in-order issue scheduler.
// FSM states, unit select and register index width.
package sched_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    U_NONE,
    U_INT,
    U_FADD,
    U_CORDIC,
    U_MEM
  } unit_e;

endpackage

// File: rtl/scoreboard.sv
// Register-pending scoreboard: set on issue, clear on writeback.
// Same-cycle set and clear of one bit: set wins.
module scoreboard
  import sched_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_i,
  input  logic [REG_W-1:0] set_idx_i,
  input  logic             clr_i,
  input  logic [REG_W-1:0] clr_idx_i,
  input  logic [REG_W-1:0] ra_i,
  input  logic [REG_W-1:0] rb_i,
  input  logic [REG_W-1:0] rc_i,
  output logic             ra_o,
  output logic             rb_o,
  output logic             rc_o,
  output logic             empty_o,
  output logic             empty_nxt_o
);

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;

  // next state: clear first so a coincident set overrides it
  always_comb begin
    sb_d = sb_q;
    if (clr_i) sb_d[clr_idx_i] = 1'b0;
    if (set_i) sb_d[set_idx_i] = 1'b1;
  end

  // pending bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign ra_o        = sb_q[ra_i];
  assign rb_o        = sb_q[rb_i];
  assign rc_o        = sb_q[rc_i];
  assign empty_o     = (sb_q == '0);
  assign empty_nxt_o = (sb_d == '0);

endmodule

// File: rtl/issue_sched.sv
// In-order issue scheduler with RAW, unit and predicate stalls.
// Optional stall counter under ISSUE_PERF_CNT_EN.
module issue_sched
  import sched_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             is_int,
  input  logic             is_imm,
  input  logic             is_fadd,
  input  logic             is_cordic,
  input  logic             is_mem,
  input  logic             is_memwrite,
  input  logic             is_predicate_setter,
  input  logic             is_predicate_getter,
  input  logic             exit,
  output logic             iss_int,
  output logic             iss_fadd,
  output logic             iss_cordic,
  output logic             iss_mem,
  input  logic             cordic_done,
  input  logic             mem_ack,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_pred,
  output logic             halted
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  state_e state_q;
  logic   halted_q;
  logic   pred_q, pred_d;
  logic   cbusy_q, cbusy_d;
  logic   mbusy_q, mbusy_d;
  logic   hit1, hit2, hit3;
  logic   sb_empty, sb_empty_nxt;
  logic   wr, raw, unit_ok, pstall;
  logic   issue, drained_nxt;
  unit_e  unit;

  assign wr = !(is_memwrite || exit);

  // decode the target unit; exit goes nowhere
  always_comb begin
    unit = U_INT;
    unique case (1'b1)
      exit:      unit = U_NONE;
      is_cordic: unit = U_CORDIC;
      is_mem:    unit = U_MEM;
      is_fadd:   unit = U_FADD;
      is_int:    unit = U_INT;
      default:   unit = U_INT;
    endcase
  end

  scoreboard #(.NREG(NREG)) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_i       (issue && wr),
    .set_idx_i   (rd),
    .clr_i       (wb_valid),
    .clr_idx_i   (wb_rd),
    .ra_i        (rs1),
    .rb_i        (rs2),
    .rc_i        (rd),
    .ra_o        (hit1),
    .rb_o        (hit2),
    .rc_o        (hit3),
    .empty_o     (sb_empty),
    .empty_nxt_o (sb_empty_nxt)
  );

  assign raw = hit1 || (!is_imm && hit2) || (wr && hit3);

  // a completing unit frees before the new issue
  always_comb begin
    unit_ok = 1'b1;
    if (unit == U_CORDIC) unit_ok = !cbusy_q || cordic_done;
    if (unit == U_MEM)    unit_ok = !mbusy_q || mem_ack;
  end

  assign pstall   = is_predicate_getter && pred_q;
  assign in_ready = (state_q == S_RUN) && !raw && unit_ok && !pstall;
  assign issue    = in_valid && in_ready;

  assign iss_int    = issue && (unit == U_INT);
  assign iss_fadd   = issue && (unit == U_FADD);
  assign iss_cordic = issue && (unit == U_CORDIC);
  assign iss_mem    = issue && (unit == U_MEM);

  assign pred_d  = (issue && is_predicate_setter) || (pred_q && !wb_pred);
  assign cbusy_d = iss_cordic || (cbusy_q && !cordic_done);
  assign mbusy_d = iss_mem || (mbusy_q && !mem_ack);

  assign drained_nxt = sb_empty_nxt && !pred_d && !cbusy_d && !mbusy_d;

  // in-flight tracking for predicate and multi-cycle units
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q  <= 1'b0;
      cbusy_q <= 1'b0;
      mbusy_q <= 1'b0;
    end else begin
      pred_q  <= pred_d;
      cbusy_q <= cbusy_d;
      mbusy_q <= mbusy_d;
    end
  end

  // run / drain / halt sequencing with registered halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (issue && exit) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drained_nxt) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        end
        S_HALT: begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= S_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted = halted_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] cnt_q;

  // saturating count of stalled cycles while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state_q == S_RUN) && in_valid && !in_ready
                 && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_cnt = cnt_q;
`endif

  logic unused;
  assign unused = sb_empty;

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched.
// Inputs change on negedge; outputs checked 1ns later.
module tb_issue_sched;
  import sched_pkg::*;

  localparam int K_INT = 0;
  localparam int K_FADD = 1;
  localparam int K_CORDIC = 2;
  localparam int K_MEMLD = 3;
  localparam int K_SET = 4;
  localparam int K_GET = 5;
  localparam int K_EXIT = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready;
  logic [3:0] rs1, rs2, rd, wb_rd;
  logic is_int, is_imm, is_fadd, is_cordic, is_mem;
  logic is_memwrite, is_ps, is_pg, exit_i;
  logic iss_int, iss_fadd, iss_cordic, iss_mem;
  logic cordic_done, mem_ack, wb_valid, wb_pred, halted;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  issue_sched #(.NREG(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .rs1                 (rs1),
    .rs2                 (rs2),
    .rd                  (rd),
    .is_int              (is_int),
    .is_imm              (is_imm),
    .is_fadd             (is_fadd),
    .is_cordic           (is_cordic),
    .is_mem              (is_mem),
    .is_memwrite         (is_memwrite),
    .is_predicate_setter (is_ps),
    .is_predicate_getter (is_pg),
    .exit                (exit_i),
    .iss_int             (iss_int),
    .iss_fadd            (iss_fadd),
    .iss_cordic          (iss_cordic),
    .iss_mem             (iss_mem),
    .cordic_done         (cordic_done),
    .mem_ack             (mem_ack),
    .wb_valid            (wb_valid),
    .wb_rd               (wb_rd),
    .wb_pred             (wb_pred),
    .halted              (halted)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .stall_cnt           (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    rs1 = 4'd0; rs2 = 4'd0; rd = 4'd0;
    is_int = 1'b0; is_imm = 1'b0; is_fadd = 1'b0;
    is_cordic = 1'b0; is_mem = 1'b0; is_memwrite = 1'b0;
    is_ps = 1'b0; is_pg = 1'b0; exit_i = 1'b0;
  endtask

  // advance to next negedge, drop one-shot sideband inputs
  task automatic cyc();
    @(negedge clk);
    cordic_done = 1'b0; mem_ack = 1'b0;
    wb_valid = 1'b0; wb_rd = 4'd0; wb_pred = 1'b0;
    idle();
  endtask

  task automatic drv(input int k, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] d,
                     input logic imm);
    idle();
    in_valid = 1'b1;
    rs1 = a; rs2 = b; rd = d; is_imm = imm;
    case (k)
      K_INT:    is_int = 1'b1;
      K_FADD:   is_fadd = 1'b1;
      K_CORDIC: is_cordic = 1'b1;
      K_MEMLD:  is_mem = 1'b1;
      K_SET:    begin is_int = 1'b1; is_ps = 1'b1; end
      K_GET:    begin is_int = 1'b1; is_pg = 1'b1; end
      default:  exit_i = 1'b1;
    endcase
  endtask

  task automatic wb(input logic [3:0] r);
    wb_valid = 1'b1;
    wb_rd = r;
  endtask

  initial begin
    rst_n = 1'b0;
    cordic_done = 1'b0; mem_ack = 1'b0;
    wb_valid = 1'b0; wb_rd = 4'd0; wb_pred = 1'b0;
    idle();
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_strobes", {iss_int, iss_fadd, iss_cordic, iss_mem}, 0);
    chk("rst_halted", halted, 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // RAW on r3
    cyc(); drv(K_FADD, 0, 0, 3, 0); #1;
    chk("raw_fadd_iss", iss_fadd, 1);
    chk("raw_fadd_noint", iss_int, 0);
    cyc(); drv(K_INT, 3, 0, 6, 1); #1;
    chk("raw_stall", in_ready, 0);
    cyc(); drv(K_INT, 3, 0, 6, 1); wb(3); #1;
    chk("raw_nobypass", in_ready, 0);
    chk("raw_nobypass_iss", iss_int, 0);
    cyc(); drv(K_INT, 3, 0, 6, 1); #1;
    chk("raw_ready", in_ready, 1);
    chk("raw_iss_int", iss_int, 1);
    cyc(); wb(6);

    // CORDIC busy
    cyc(); drv(K_CORDIC, 0, 0, 1, 1); #1;
    chk("cor1_iss", iss_cordic, 1);
    cyc(); drv(K_CORDIC, 0, 0, 2, 1); #1;
    chk("cor_busy", in_ready, 0);
    chk("cor_busy_iss", iss_cordic, 0);
    cyc(); drv(K_CORDIC, 0, 0, 2, 1); cordic_done = 1'b1; wb(1); #1;
    chk("cor_done_ready", in_ready, 1);
    chk("cor_done_iss", iss_cordic, 1);
    cyc(); cordic_done = 1'b1; wb(2);
    cyc(); drv(K_INT, 1, 2, 1, 0); #1;
    chk("cor_cleared", iss_int, 1);
    cyc(); wb(1);

    // predicate
    cyc(); drv(K_SET, 0, 0, 4, 1); #1;
    chk("pred_set_iss", iss_int, 1);
    cyc(); drv(K_GET, 0, 0, 7, 1); wb(4); #1;
    chk("pred_stall", in_ready, 0);
    cyc(); drv(K_GET, 0, 0, 7, 1); wb_pred = 1'b1; #1;
    chk("pred_stall_wb", in_ready, 0);
    cyc(); drv(K_GET, 0, 0, 7, 1); #1;
    chk("pred_get_iss", iss_int, 1);
    cyc(); wb(7);

    // exit drains an in-flight load
    cyc(); drv(K_MEMLD, 0, 0, 5, 1); #1;
    chk("ld_iss", iss_mem, 1);
    cyc(); drv(K_EXIT, 0, 0, 0, 1); #1;
    chk("exit_ready", in_ready, 1);
    chk("exit_nostrobe", {iss_int, iss_fadd, iss_cordic, iss_mem}, 0);
    cyc(); drv(K_INT, 0, 0, 8, 1); #1;
    chk("drain_ready", in_ready, 0);
    chk("drain_nohalt", halted, 0);
    cyc(); mem_ack = 1'b1; wb(5); #1;
    chk("drain_ack_nohalt", halted, 0);
    cyc(); #1;
    chk("halted", halted, 1);
    cyc(); drv(K_INT, 0, 0, 8, 1); #1;
    chk("halt_sticky", halted, 1);
    chk("halt_ready", in_ready, 0);

    // reset while draining with CORDIC busy
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc(); drv(K_CORDIC, 0, 0, 9, 1); #1;
    chk("r2_cor_iss", iss_cordic, 1);
    cyc(); drv(K_EXIT, 0, 0, 0, 1); #1;
    chk("r2_exit", in_ready, 1);
    cyc(); drv(K_INT, 0, 0, 10, 1); #1;
    chk("r2_drain", in_ready, 0);
    rst_n = 1'b0; #1;
    chk("r2_rst_halted", halted, 0);
    cyc(); rst_n = 1'b1;
    drv(K_INT, 9, 9, 10, 0); #1;
    chk("r2_int_ready", in_ready, 1);
    chk("r2_int_iss", iss_int, 1);
    cyc(); cordic_done = 1'b1; wb(9);
    drv(K_CORDIC, 0, 0, 11, 1); #1;
    chk("r2_cor_free", iss_cordic, 1);

`ifdef ISSUE_PERF_CNT_EN
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; #1;
    chk("cnt_rst", stall_cnt, 0);
    cyc(); drv(K_CORDIC, 0, 0, 1, 1);
    cyc(); drv(K_CORDIC, 0, 0, 2, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
    end
    @(negedge clk); #1;
    chk("cnt_7", stall_cnt, 7);
`endif

    cyc();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
